// File: rtl/range_check_reg_if.sv
// Range-check bus: input word with its valid qualifier, plus the registered
// in-range/below/above flags that come back one cycle later.
interface range_check_reg_if #(
  parameter int unsigned WIDTH = 7
);
  // dat_valid is a pure qualifier for dat.
  // It has no ready partner: every cycle is accepted and is returned as inr_valid.
  logic             dat_valid;
  logic [WIDTH-1:0] dat;
  logic             inr_valid;
  logic             inr;
  logic             below;
  logic             above;

  modport master (
    output dat_valid, dat,
    input  inr_valid, inr, below, above
  );

  modport slave (
    input  dat_valid, dat,
    output inr_valid, inr, below, above
  );
endinterface

// File: rtl/range_check_reg.sv
// Registered constant-range detector: flags dat in [LOWER_BOUND, UPPER_BOUND),
// with three interchangeable in-range comparator structures selected by METHOD.
module range_check_reg #(
  parameter int unsigned WIDTH       = 7,
  parameter int unsigned LOWER_BOUND = 85,
  parameter int unsigned UPPER_BOUND = 120,
  parameter int unsigned METHOD      = 2
) (
  input logic              clk,
  input logic              rst_n,
  range_check_reg_if.slave bus
);

  localparam longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1;

  generate
    if (WIDTH < 1 || WIDTH > 32 || LOWER_BOUND >= UPPER_BOUND ||
        longint'(UPPER_BOUND) > MAX_VAL || METHOD > 2) begin : g_bad_params
      $fatal(1, "range_check_reg: illegal parameter set");
    end
  endgenerate

  localparam logic [WIDTH-1:0] LB   = WIDTH'(LOWER_BOUND);
  localparam logic [WIDTH-1:0] UB   = WIDTH'(UPPER_BOUND);
  localparam logic [WIDTH-1:0] SPAN = UB - LB;

  // Highest bit where the bounds diverge (UB=1, LB=0); all bits above it are equal.
  function automatic int find_split();
    int s;
    s = 0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (UB[i] && !LB[i]) s = i;
    end
    return s;
  endfunction

  localparam int SPLIT = find_split();

  logic inr_c;
  logic below_c;
  logic above_c;

  assign below_c = bus.dat < LB;
  assign above_c = bus.dat >= UB;

  generate
    if (METHOD == 0) begin : g_generic
      assign inr_c = (bus.dat >= LB) && (bus.dat < UB);
    end else if (METHOD == 1) begin : g_subtract
      // Offset wraps modulo 2^WIDTH, so values below LB land above SPAN
      // and the final subtraction produces no borrow for them.
      logic [WIDTH-1:0] offs;
      logic [WIDTH+1:0] res;
      assign offs  = bus.dat - LB;
      assign res   = {2'b00, offs} - {2'b00, SPAN};
      assign inr_c = (res >> (WIDTH + 1)) != '0;
    end else begin : g_split
      logic eq;
      logic over;
      logic ou;

      if (SPLIT == int'(WIDTH) - 1) begin : g_eq_empty
        assign eq = 1'b1;
      end else begin : g_eq_field
        assign eq = bus.dat[WIDTH-1:SPLIT+1] == UB[WIDTH-1:SPLIT+1];
      end

      assign over = !bus.dat[SPLIT];

      // Split bit clear: only the lower bound can fail; set: only the upper.
      if (SPLIT == 0) begin : g_ou_empty
        assign ou = over;
      end else begin : g_ou_field
        assign ou = over ? (bus.dat[SPLIT-1:0] >= LB[SPLIT-1:0])
                         : (bus.dat[SPLIT-1:0] <  UB[SPLIT-1:0]);
      end

      assign inr_c = eq & ou;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.inr_valid <= 1'b0;
      bus.inr       <= 1'b0;
      bus.below     <= 1'b0;
      bus.above     <= 1'b0;
    end else begin
      bus.inr_valid <= bus.dat_valid;
      bus.inr       <= inr_c;
      bus.below     <= below_c;
      bus.above     <= above_c;
    end
  end

endmodule

// File: tb/tb_range_check_reg.sv
// Directed bench for range_check_reg: reset, boundary/split vectors, exhaustive
// sweeps of all three METHODs and of two degenerate-split configurations.
module tb_range_check_reg;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  range_check_reg_if #(.WIDTH(7)) if_m0 ();
  range_check_reg_if #(.WIDTH(7)) if_m1 ();
  range_check_reg_if #(.WIDTH(7)) if_m2 ();
  range_check_reg_if #(.WIDTH(4)) if_d0 ();
  range_check_reg_if #(.WIDTH(4)) if_d1 ();

  range_check_reg #(.WIDTH(7), .LOWER_BOUND(85), .UPPER_BOUND(120), .METHOD(0))
    u_m0 (.clk(clk), .rst_n(rst_n), .bus(if_m0));
  range_check_reg #(.WIDTH(7), .LOWER_BOUND(85), .UPPER_BOUND(120), .METHOD(1))
    u_m1 (.clk(clk), .rst_n(rst_n), .bus(if_m1));
  range_check_reg #(.WIDTH(7), .LOWER_BOUND(85), .UPPER_BOUND(120), .METHOD(2))
    u_m2 (.clk(clk), .rst_n(rst_n), .bus(if_m2));
  range_check_reg #(.WIDTH(4), .LOWER_BOUND(4), .UPPER_BOUND(5), .METHOD(2))
    u_d0 (.clk(clk), .rst_n(rst_n), .bus(if_d0));
  range_check_reg #(.WIDTH(4), .LOWER_BOUND(0), .UPPER_BOUND(15), .METHOD(2))
    u_d1 (.clk(clk), .rst_n(rst_n), .bus(if_d1));

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] dat;
    logic       valid;
    logic       e_inr;
    logic       e_below;
    logic       e_above;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic drive_def(input logic [6:0] d, input logic v);
    if_m0.dat = d; if_m0.dat_valid = v;
    if_m1.dat = d; if_m1.dat_valid = v;
    if_m2.dat = d; if_m2.dat_valid = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_m2_zero(input string tag);
    chk({tag, " inr"},       32'(if_m2.inr),       0);
    chk({tag, " below"},     32'(if_m2.below),     0);
    chk({tag, " above"},     32'(if_m2.above),     0);
    chk({tag, " inr_valid"}, 32'(if_m2.inr_valid), 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive_def(7'd0, 1'b0);
    if_d0.dat = '0; if_d0.dat_valid = 1'b1;
    if_d1.dat = '0; if_d1.dat_valid = 1'b1;

    vecs[0] = '{7'd84,  1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{7'd85,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{7'd119, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{7'd120, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{7'd96,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{7'd88,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{7'd64,  1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{7'd127, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{7'd0,   1'b1, 1'b0, 1'b1, 1'b0};

    // Reset held with clocks running and an in-range word on the input
    drive_def(7'd100, 1'b1);
    repeat (3) step();
    chk_m2_zero("rst_hold");

    #2 rst_n = 1'b1;
    step();
    chk("post_rst inr",       32'(if_m2.inr),       1);
    chk("post_rst inr_valid", 32'(if_m2.inr_valid), 1);

    // Asynchronous assertion mid-cycle must clear outputs before any edge
    #2 rst_n = 1'b0;
    #1;
    chk_m2_zero("async_rst");
    step();
    chk_m2_zero("async_rst_held");
    #2 rst_n = 1'b1;

    // Boundary and split-bit vectors
    for (int i = 0; i < 9; i++) begin
      drive_def(vecs[i].dat, vecs[i].valid);
      step();
      chk($sformatf("vec%0d m2 inr", i),   32'(if_m2.inr),       32'(vecs[i].e_inr));
      chk($sformatf("vec%0d m2 below", i), 32'(if_m2.below),     32'(vecs[i].e_below));
      chk($sformatf("vec%0d m2 above", i), 32'(if_m2.above),     32'(vecs[i].e_above));
      chk($sformatf("vec%0d m2 valid", i), 32'(if_m2.inr_valid), 32'(vecs[i].valid));
      chk($sformatf("vec%0d m0 inr", i),   32'(if_m0.inr),       32'(vecs[i].e_inr));
      chk($sformatf("vec%0d m1 inr", i),   32'(if_m1.inr),       32'(vecs[i].e_inr));
    end

    // Exhaustive sweep of all three methods, dat_valid toggling
    for (int d = 0; d < 128; d++) begin
      logic exp_inr;
      logic exp_v;
      exp_inr = (d >= 85) && (d < 120);
      exp_v   = d[0];
      drive_def(7'(d), exp_v);
      step();
      chk($sformatf("sweep m0 inr d=%0d", d), 32'(if_m0.inr), 32'(exp_inr));
      chk($sformatf("sweep m1 inr d=%0d", d), 32'(if_m1.inr), 32'(exp_inr));
      chk($sformatf("sweep m2 inr d=%0d", d), 32'(if_m2.inr), 32'(exp_inr));
      chk($sformatf("sweep m0 valid d=%0d", d), 32'(if_m0.inr_valid), 32'(exp_v));
      chk($sformatf("sweep m1 valid d=%0d", d), 32'(if_m1.inr_valid), 32'(exp_v));
      chk($sformatf("sweep m2 valid d=%0d", d), 32'(if_m2.inr_valid), 32'(exp_v));
      chk($sformatf("sweep m0 onehot d=%0d", d),
          32'($countones({if_m0.inr, if_m0.below, if_m0.above})), 1);
      chk($sformatf("sweep m1 onehot d=%0d", d),
          32'($countones({if_m1.inr, if_m1.below, if_m1.above})), 1);
      chk($sformatf("sweep m2 onehot d=%0d", d),
          32'($countones({if_m2.inr, if_m2.below, if_m2.above})), 1);
      chk($sformatf("sweep m2 below d=%0d", d), 32'(if_m2.below), 32'(d < 85));
      chk($sformatf("sweep m2 above d=%0d", d), 32'(if_m2.above), 32'(d >= 120));
    end

    // Degenerate splits: SPLIT=0 (d0) and empty equal field (d1)
    for (int d = 0; d < 16; d++) begin
      if_d0.dat = 4'(d);
      if_d1.dat = 4'(d);
      step();
      chk($sformatf("d0 inr d=%0d", d),   32'(if_d0.inr),   32'(d == 4));
      chk($sformatf("d0 below d=%0d", d), 32'(if_d0.below), 32'(d < 4));
      chk($sformatf("d0 above d=%0d", d), 32'(if_d0.above), 32'(d >= 5));
      chk($sformatf("d1 inr d=%0d", d),   32'(if_d1.inr),   32'(d < 15));
      chk($sformatf("d1 below d=%0d", d), 32'(if_d1.below), 0);
      chk($sformatf("d1 above d=%0d", d), 32'(if_d1.above), 32'(d == 15));
      chk($sformatf("d1 valid d=%0d", d), 32'(if_d1.inr_valid), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
